// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider (also used by the multiplier).
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  localparam int DIV_MAX_W = 64;

  function automatic int div_iters(input int width, input int unroll);
    return width / unroll;
  endfunction

  // Conditional two's-complement negate; callers zero-extend in and truncate out.
  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                    input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if no borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dsr,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_dsr});
  // Incoming remainder is below the divisor, so the result always fits WIDTH bits.
  assign o_rem   = WIDTH'(w_shift - (o_qbit ? {1'b0, i_dsr} : {(WIDTH+1){1'b0}}));

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, UNROLL quotient bits per cycle plus one sign-fix cycle.
// Optional DIV_ZERO_TRAP_EN: zero divisor completes next cycle with o_dz set.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_div_signed,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_busy,
  output logic             o_done
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             o_dz
`endif
);

  localparam int N  = div_iters(WIDTH, UNROLL);
  localparam int CW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_e r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;

  logic             w_start_ok;
  logic             w_go;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_rem [UNROLL+1];
  logic [UNROLL-1:0] w_qbit;

  assign w_start_ok = (r_state == ST_IDLE) && i_start;

`ifdef DIV_ZERO_TRAP_EN
  logic r_dz;
  logic w_dz_hit;
  assign w_dz_hit = w_start_ok && (i_divisor == '0);
  assign w_go     = w_start_ok && (i_divisor != '0);
  assign o_dz     = r_dz;
`else
  assign w_go     = w_start_ok;
`endif

  assign w_dvd_mag = WIDTH'(cond_neg(DIV_MAX_W'(i_dividend),
                                     i_div_signed & i_dividend[WIDTH-1]));
  assign w_dsr_mag = WIDTH'(cond_neg(DIV_MAX_W'(i_divisor),
                                     i_div_signed & i_divisor[WIDTH-1]));
  assign w_q_fix   = WIDTH'(cond_neg(DIV_MAX_W'(r_quo), r_neg_q));
  assign w_r_fix   = WIDTH'(cond_neg(DIV_MAX_W'(r_rem), r_neg_r));

  // r_quo holds the unconsumed dividend bits on top and retired quotient bits below.
  assign w_rem[0] = r_rem;
  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (w_rem[k]),
      .i_dsr  (r_dsr),
      .i_bit  (r_quo[WIDTH-1-k]),
      .o_rem  (w_rem[k+1]),
      .o_qbit (w_qbit[UNROLL-1-k])
    );
  end
  assign w_quo_next = (r_quo << UNROLL) | WIDTH'(w_qbit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_next = ST_ITER;
      ST_ITER: begin
        if (i_abort)            w_next = ST_IDLE;
        else if (r_cnt == '0)   w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_dz   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_quo   <= w_dvd_mag;
            r_dsr   <= w_dsr_mag;
            r_rem   <= '0;
            r_cnt   <= CNT_LAST;
            r_neg_q <= i_div_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            r_neg_r <= i_div_signed & i_dividend[WIDTH-1];
          end
`ifdef DIV_ZERO_TRAP_EN
          if (w_dz_hit) begin
            r_q    <= '1;
            r_r    <= i_dividend;
            r_done <= 1'b1;
            r_dz   <= 1'b1;
          end
`endif
        end
        ST_ITER: begin
          if (!i_abort) begin
            r_rem <= w_rem[UNROLL];
            r_quo <= w_quo_next;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          if (!i_abort) begin
            r_q    <= w_q_fix;
            r_r    <= w_r_fix;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_r    = r_r;
  assign o_done = r_done;

endmodule
